// File: rtl/ysyx_25030081_pkg.sv
// ============================================================================
// Module   : ysyx_25030081_pkg
// Brief    : Shared types and constants for the ysyx_25030081 PC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_25030081_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } pc_state_t;

    localparam logic [1:0]  FC_NONE     = 2'b00;
    localparam logic [1:0]  FC_BUS      = 2'b01;
    localparam logic [1:0]  FC_MISALIGN = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/ysyx_25030081_cnt.sv
// ============================================================================
// Module   : ysyx_25030081_cnt
// Brief    : Enable-controlled wrapping up-counter (retired/cycle counts).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25030081_cnt #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_25030081_pc_ctrl.sv
// ============================================================================
// Module   : ysyx_25030081_pc_ctrl
// Brief    : Multi-cycle PC sequencer: fetch, hand to execute, commit next PC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25030081_pc_ctrl
    import ysyx_25030081_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                    CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ifu_req_valid,
    input  logic                  ifu_req_ready,
    output logic [DATA_WIDTH-1:0] ifu_req_addr,
    input  logic                  ifu_rsp_valid,
    output logic                  ifu_rsp_ready,
    input  logic [DATA_WIDTH-1:0] ifu_rsp_data,
    input  logic                  ifu_rsp_err,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  inst_valid,
    input  logic                  exu_done,
    input  logic [DATA_WIDTH-1:0] next_pc,
    input  logic                  halt_req,
    output logic                  halted,
    output logic                  fault,
    output logic [1:0]            fault_cause,
    output logic [CNT_WIDTH-1:0]  instret
);

    pc_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  fault_q, fault_d;
    logic [1:0]            cause_q, cause_d;
    logic                  retire;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        cause_d = cause_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (ifu_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ifu_rsp_valid) begin
                    if (ifu_rsp_err) begin
                        fault_d = 1'b1;
                        cause_d = FC_BUS;
                        state_d = S_HALT;
                    end else begin
                        inst_d  = ifu_rsp_data;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                // ebreak retires; a misaligned target does not, and the PC is kept
                if (exu_done) begin
                    if (halt_req) begin
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end else if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        cause_d = FC_MISALIGN;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            fault_q <= 1'b0;
            cause_q <= FC_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    ysyx_25030081_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (retire),
        .cnt_o (instret)
    );

    assign ifu_req_valid = (state_q == S_FETCH);
    assign ifu_rsp_ready = (state_q == S_WAIT);
    assign inst_valid    = (state_q == S_EXEC);
    assign halted        = (state_q == S_HALT);
    assign ifu_req_addr  = pc_q;
    assign pc            = pc_q;
    assign inst          = inst_q;
    assign fault         = fault_q;
    assign fault_cause   = cause_q;

endmodule

`default_nettype wire
